// File: rtl/tmds_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_word_aligner
//  Purpose  : Recovers the 10-bit TMDS word boundary from an IDES10 stream by
//             hunting for DVI control tokens and emits aligned words plus a
//             decoded control-token flag. One instance per TMDS channel.
//  Revision : 1.0  initial release
// ============================================================================
module tmds_word_aligner #(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_CYCLES = 4096,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_data,
    output logic [9:0] o_data,
    output logic       o_ctrl_valid,
    output logic [1:0] o_ctrl,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int CYC_W  = $clog2(SEARCH_CYCLES) + 1;
    localparam int IDLE_W = $clog2(LOSS_CYCLES) + 1;

    localparam logic [RUN_W-1:0]  c_RUN_LAST  = RUN_W'(CTRL_RUN - 1);
    localparam logic [CYC_W-1:0]  c_CYC_LAST  = CYC_W'(SEARCH_CYCLES - 1);
    localparam logic [IDLE_W-1:0] c_IDLE_LAST = IDLE_W'(LOSS_CYCLES - 1);
    localparam logic [3:0]        c_OFF_MAX   = 4'd9;

    localparam logic [9:0] c_TOK_00 = 10'b1101010100;
    localparam logic [9:0] c_TOK_01 = 10'b0010101011;
    localparam logic [9:0] c_TOK_10 = 10'b0101010100;
    localparam logic [9:0] c_TOK_11 = 10'b1010101011;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [9:0]          r_cur;
    logic [9:0]          r_prev;
    logic [CYC_W-1:0]    r_cyc;
    logic [RUN_W-1:0]    r_run;
    logic [IDLE_W-1:0]   r_idle;

    logic [19:0]         w_win;
    logic [9:0]          w_aligned;
    logic                w_is_tok;
    logic [1:0]          w_tok_ctrl;

    // Older word sits in the low half so that bit 0 stays the earliest bit.
    always_comb begin
        w_win     = {r_cur, r_prev};
        w_aligned = w_win[9:0];
        for (int k = 1; k < 10; k++) begin
            if (o_offset == 4'(k)) begin
                w_aligned = w_win[k +: 10];
            end
        end
    end

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_ctrl = 2'b00;
        case (w_aligned)
            c_TOK_00: w_tok_ctrl = 2'b00;
            c_TOK_01: w_tok_ctrl = 2'b01;
            c_TOK_10: w_tok_ctrl = 2'b10;
            c_TOK_11: w_tok_ctrl = 2'b11;
            default: begin
                w_is_tok   = 1'b0;
                w_tok_ctrl = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_HUNT;
            r_cur        <= '0;
            r_prev       <= '0;
            r_cyc        <= '0;
            r_run        <= '0;
            r_idle       <= '0;
            o_data       <= '0;
            o_ctrl_valid <= 1'b0;
            o_ctrl       <= 2'b00;
            o_locked     <= 1'b0;
            o_offset     <= 4'd0;
        end else begin
            r_cur        <= i_data;
            r_prev       <= r_cur;
            o_data       <= w_aligned;
            o_ctrl_valid <= w_is_tok;
            o_ctrl       <= w_tok_ctrl;

            case (r_state)
                ST_HUNT: begin
                    // Lock wins over a slip landing on the same cycle.
                    if (w_is_tok && (r_run == c_RUN_LAST)) begin
                        r_state  <= ST_LOCKED;
                        o_locked <= 1'b1;
                        r_idle   <= '0;
                        r_run    <= '0;
                        r_cyc    <= '0;
                    end else if (r_cyc == c_CYC_LAST) begin
                        o_offset <= (o_offset == c_OFF_MAX) ? 4'd0 : o_offset + 4'd1;
                        r_cyc    <= '0;
                        r_run    <= '0;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                        r_run <= w_is_tok ? r_run + 1'b1 : '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_is_tok) begin
                        r_idle <= '0;
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_state  <= ST_HUNT;
                        o_locked <= 1'b0;
                        r_cyc    <= '0;
                        r_run    <= '0;
                        r_idle   <= '0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_word_aligner
//  Purpose  : Self-checking bench for tmds_word_aligner with shortened
//             search/loss windows so every hunting scenario stays short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmds_word_aligner;

    localparam int RUN    = 8;
    localparam int SEARCH = 64;
    localparam int LOSS   = 64;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    typedef struct packed {
        logic [9:0] data;
        logic       valid;
        logic [1:0] ctrl;
        logic       locked;
        logic [3:0] offset;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic [9:0] o_data;
    logic       o_ctrl_valid;
    logic [1:0] o_ctrl;
    logic       o_locked;
    logic [3:0] o_offset;

    int n_vec = 0;
    int n_err = 0;

    exp_t       q[$];
    logic [9:0] wl[$];
    exp_t       el[$];

    tmds_word_aligner #(
        .CTRL_RUN      (RUN),
        .SEARCH_CYCLES (SEARCH),
        .LOSS_CYCLES   (LOSS)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (din),
        .o_data       (o_data),
        .o_ctrl_valid (o_ctrl_valid),
        .o_ctrl       (o_ctrl),
        .o_locked     (o_locked),
        .o_offset     (o_offset)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [9:0] d, input logic v, input logic [1:0] c,
                                input logic lk);
        exp_t e;
        e.data = d; e.valid = v; e.ctrl = c; e.locked = lk; e.offset = 4'd0;
        return e;
    endfunction

    // Serial line model: token symbols start at bit 'ph'; blocks of 12 tokens
    // followed by 28 zero symbols, packed 10 bits per word, earliest bit in bit 0.
    function automatic logic [9:0] gen(input int m, input int ph, input logic [9:0] tok);
        logic [9:0] w;
        int p, s, b;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            p = 10 * m + i;
            if (p >= ph) begin
                s = (p - ph) / 10;
                b = (p - ph) % 10;
                w[i] = ((s % 40) < 12) ? tok[b] : 1'b0;
            end
        end
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 10'h2B7;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (o_data !== 10'd0) begin n_err++; $display("FAIL reset_data: got %h want 000", o_data); end
        n_vec++; if (o_ctrl_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_ctrl_valid); end
        n_vec++; if (o_ctrl !== 2'b00) begin n_err++; $display("FAIL reset_ctrl: got %b want 00", o_ctrl); end
        n_vec++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", o_locked); end
        n_vec++; if (o_offset !== 4'd0) begin n_err++; $display("FAIL reset_offset: got %0d want 0", o_offset); end
        rst = 1'b0;
    endtask

    task automatic test_aligned_lock();
        do_reset();
        q.delete(); wl.delete(); el.delete();
        for (int i = 0; i < RUN; i++) begin
            wl.push_back(T00); el.push_back(mk(T00, 1'b1, 2'b00, i >= RUN - 1));
        end
        wl.push_back(10'h3FF); el.push_back(mk(10'h3FF, 1'b0, 2'b00, 1'b1));
        wl.push_back(10'h000); el.push_back(mk(10'h000, 1'b0, 2'b00, 1'b1));
        wl.push_back(10'h155); el.push_back(mk(10'h155, 1'b0, 2'b00, 1'b1));
        wl.push_back(10'h2AA); el.push_back(mk(10'h2AA, 1'b0, 2'b00, 1'b1));
        wl.push_back(T01);     el.push_back(mk(T01, 1'b1, 2'b01, 1'b1));
        wl.push_back(T10);     el.push_back(mk(T10, 1'b1, 2'b10, 1'b1));
        wl.push_back(T11);     el.push_back(mk(T11, 1'b1, 2'b11, 1'b1));
        wl.push_back(10'h1A5); el.push_back(mk(10'h1A5, 1'b0, 2'b00, 1'b1));
        for (int i = 0; i < 3; i++) begin
            wl.push_back(10'h000); el.push_back(mk(10'h000, 1'b0, 2'b00, 1'b1));
        end
        for (int i = 0; i < wl.size(); i++) begin
            @(posedge clk); #1;
            if (q.size() >= 3) begin
                exp_t x;
                x = q.pop_front();
                n_vec++;
                if ({o_data, o_ctrl_valid, o_ctrl, o_locked, o_offset} !== x) begin
                    n_err++;
                    $display("FAIL aligned_word[%0d]: got d=%h v=%b c=%b lk=%b off=%0d want d=%h v=%b c=%b lk=%b off=%0d",
                             i - 3, o_data, o_ctrl_valid, o_ctrl, o_locked, o_offset,
                             x.data, x.valid, x.ctrl, x.locked, x.offset);
                end
            end
            din = wl[i];
            q.push_back(el[i]);
        end
        q.delete();
    endtask

    task automatic test_loss_relock();
        do_reset();
        q.delete(); wl.delete(); el.delete();
        for (int i = 0; i < RUN; i++) begin
            wl.push_back(T00); el.push_back(mk(T00, 1'b1, 2'b00, i >= RUN - 1));
        end
        for (int k = 1; k <= LOSS + 2; k++) begin
            wl.push_back(10'h000); el.push_back(mk(10'h000, 1'b0, 2'b00, k < LOSS));
        end
        for (int i = 0; i < RUN - 1; i++) begin
            wl.push_back(T00); el.push_back(mk(T00, 1'b1, 2'b00, 1'b0));
        end
        wl.push_back(10'h0F0); el.push_back(mk(10'h0F0, 1'b0, 2'b00, 1'b0));
        for (int i = 0; i < RUN; i++) begin
            wl.push_back(T00); el.push_back(mk(T00, 1'b1, 2'b00, i == RUN - 1));
        end
        for (int i = 0; i < 3; i++) begin
            wl.push_back(10'h000); el.push_back(mk(10'h000, 1'b0, 2'b00, 1'b1));
        end
        for (int i = 0; i < wl.size(); i++) begin
            @(posedge clk); #1;
            if (q.size() >= 3) begin
                exp_t x;
                x = q.pop_front();
                n_vec++;
                if ({o_data, o_ctrl_valid, o_ctrl, o_locked, o_offset} !== x) begin
                    n_err++;
                    $display("FAIL loss_relock[%0d]: got d=%h v=%b c=%b lk=%b off=%0d want d=%h v=%b c=%b lk=%b off=%0d",
                             i - 3, o_data, o_ctrl_valid, o_ctrl, o_locked, o_offset,
                             x.data, x.valid, x.ctrl, x.locked, x.offset);
                end
            end
            din = wl[i];
            q.push_back(el[i]);
        end
        q.delete();
    endtask

    task automatic test_slip_to_7();
        logic [3:0] prev_off, exp_next;
        int since, steps, m;
        logic done;
        do_reset();
        prev_off = 4'd0; exp_next = 4'd1; since = 0; steps = 0; m = 0; done = 1'b0;
        din = gen(m, 7, T01);
        for (int c = 0; c < 12 * SEARCH && !done; c++) begin
            @(posedge clk); #1;
            since++;
            if (o_offset !== prev_off) begin
                n_vec++;
                if (o_offset !== exp_next || since != SEARCH) begin
                    n_err++;
                    $display("FAIL slip7_step: got off=%0d after %0d cycles want off=%0d after %0d",
                             o_offset, since, exp_next, SEARCH);
                end
                prev_off = o_offset;
                exp_next = (exp_next == 4'd9) ? 4'd0 : exp_next + 4'd1;
                since = 0;
                steps++;
            end
            if (o_locked === 1'b1) done = 1'b1;
            m++;
            din = gen(m, 7, T01);
        end
        n_vec++; if (o_locked !== 1'b1) begin n_err++; $display("FAIL slip7_locked: got %b want 1", o_locked); end
        n_vec++; if (o_offset !== 4'd7) begin n_err++; $display("FAIL slip7_offset: got %0d want 7", o_offset); end
        n_vec++; if (steps != 7) begin n_err++; $display("FAIL slip7_steps: got %0d want 7", steps); end
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #1;
            if (o_ctrl_valid === 1'b1) done = 1'b1;
            m++;
            din = gen(m, 7, T01);
        end
        n_vec++;
        if (!done || o_ctrl !== 2'b01 || o_data !== T01) begin
            n_err++;
            $display("FAIL slip7_token: got v=%b c=%b d=%h want v=1 c=01 d=%h", o_ctrl_valid, o_ctrl, o_data, T01);
        end
    endtask

    task automatic test_wrap_to_2();
        logic [3:0] prev_off, exp_next;
        int since, steps, m;
        logic done, phase_b, saw_wrap;
        do_reset();
        prev_off = 4'd0; exp_next = 4'd1; since = 0; steps = 0; m = 0;
        done = 1'b0; phase_b = 1'b0; saw_wrap = 1'b0;
        din = '0;
        for (int c = 0; c < 20 * SEARCH && !done; c++) begin
            @(posedge clk); #1;
            since++;
            if (o_offset !== prev_off) begin
                n_vec++;
                if (o_offset !== exp_next || since != SEARCH) begin
                    n_err++;
                    $display("FAIL wrap_step: got off=%0d after %0d cycles want off=%0d after %0d",
                             o_offset, since, exp_next, SEARCH);
                end
                if (prev_off == 4'd9 && o_offset == 4'd0) saw_wrap = 1'b1;
                prev_off = o_offset;
                exp_next = (exp_next == 4'd9) ? 4'd0 : exp_next + 4'd1;
                since = 0;
                steps++;
                if (o_offset == 4'd9) phase_b = 1'b1;
            end
            if (o_locked === 1'b1) done = 1'b1;
            if (phase_b) begin
                din = gen(m, 2, T11);
                m++;
            end else begin
                din = '0;
            end
        end
        n_vec++; if (o_locked !== 1'b1) begin n_err++; $display("FAIL wrap_locked: got %b want 1", o_locked); end
        n_vec++; if (o_offset !== 4'd2) begin n_err++; $display("FAIL wrap_offset: got %0d want 2", o_offset); end
        n_vec++; if (saw_wrap !== 1'b1 || steps != 12) begin
            n_err++; $display("FAIL wrap_path: got wrap=%b steps=%0d want wrap=1 steps=12", saw_wrap, steps);
        end
    endtask

    task automatic test_reset_while_locked();
        int m;
        logic done;
        do_reset();
        m = 0; done = 1'b0;
        din = gen(m, 5, T00);
        for (int c = 0; c < 8 * SEARCH && !done; c++) begin
            @(posedge clk); #1;
            if (o_locked === 1'b1) done = 1'b1;
            m++;
            din = gen(m, 5, T00);
        end
        n_vec++; if (o_locked !== 1'b1 || o_offset !== 4'd5) begin
            n_err++; $display("FAIL rst5_prelock: got lk=%b off=%0d want lk=1 off=5", o_locked, o_offset);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        m++; din = gen(m, 5, T00);
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if ({o_data, o_ctrl_valid, o_ctrl, o_locked, o_offset} !== 18'd0) begin
            n_err++;
            $display("FAIL rst5_outputs: got d=%h v=%b c=%b lk=%b off=%0d want all 0",
                     o_data, o_ctrl_valid, o_ctrl, o_locked, o_offset);
        end
        m++; din = gen(m, 5, T00);
        for (int c = 1; c <= SEARCH; c++) begin
            @(posedge clk); #1;
            if (c == SEARCH - 1) begin
                n_vec++;
                if (o_offset !== 4'd0 || o_locked !== 1'b0) begin
                    n_err++; $display("FAIL rst5_hunt_hold: got lk=%b off=%0d want lk=0 off=0", o_locked, o_offset);
                end
            end
            if (c == SEARCH) begin
                n_vec++;
                if (o_offset !== 4'd1 || o_locked !== 1'b0) begin
                    n_err++; $display("FAIL rst5_hunt_slip: got lk=%b off=%0d want lk=0 off=1", o_locked, o_offset);
                end
            end
            m++; din = gen(m, 5, T00);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_slip_to_7();
        test_wrap_to_2();
        test_loss_relock();
        test_reset_while_locked();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
